// File: rtl/ha_collect_pkg.sv
// Shared definitions for the RSFQ half-adder result collector.
//   DEF_WORD_W / DEF_FIFO_DEPTH : default word width and FIFO depth
//   state_e                     : collector FSM states
//   WARMUP_CYC                  : cycles of strobe masking after reset
//   ERR_W                       : protocol error counter width
package ha_collect_pkg;
  localparam int DEF_WORD_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int WARMUP_CYC     = 3;
  localparam int ERR_W          = 8;

  typedef enum logic [1:0] {WARMUP, IDLE, COLLECT} state_e;
endpackage

// File: rtl/ha_toggle_sync.sv
// Toggle-line receiver: 2-flop synchronizer, previous-value flop and a
// registered XOR giving a 1-cycle strobe per line transition.
//   clk   : host clock
//   rst   : synchronous active-high reset (clears the strobe)
//   line  : toggle-encoded pulse line (asynchronous)
//   pulse : 1-cycle strobe, high in the cycle after the 3rd edge that sees
//           the new level
module ha_toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic pulse
);
  logic meta, sync, prev;

  // The level pipeline keeps tracking the line during reset, so the level
  // present at reset becomes the baseline rather than a phantom toggle.
  always_ff @(posedge clk) begin
    meta <= line;
    sync <= meta;
    prev <= sync;
    if (rst) pulse <= 1'b0;
    else     pulse <= sync ^ prev;
  end
endmodule

// File: rtl/ha_result_collector.sv
// Collector for the RSFQ half-adder: turns toggle-encoded sum/carry/SFQ-clock
// lines into packed WORD_W-bit words buffered in a valid/ready FIFO.
//   clk, rst           : host clock, synchronous active-high reset
//   sfq_clk_in         : SFQ clock line (toggle-encoded)
//   s_in, cout_in      : sum / carry lines (toggle-encoded)
//   word_s, word_c     : FIFO head words, bit 0 = first window
//   word_valid         : FIFO non-empty
//   word_ready         : consumer accepts head
//   overflow           : sticky, a completed word was dropped
//   err_cnt            : saturating protocol error count (HA_COLLECT_CHECK_EN)
// Optional feature macro: HA_COLLECT_CHECK_EN
module ha_result_collector
  import ha_collect_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sfq_clk_in,
  input  logic              s_in,
  input  logic              cout_in,
  output logic [WORD_W-1:0] word_s,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow
`ifdef HA_COLLECT_CHECK_EN
  ,output logic [ERR_W-1:0] err_cnt
`endif
);
  localparam int IDX_W = $clog2(WORD_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // ---------------- line receivers: [0]=sfq, [1]=s, [2]=cout
  logic [2:0] lines, strobes;
  assign lines = {cout_in, s_in, sfq_clk_in};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    ha_toggle_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .line  (lines[g]),
      .pulse (strobes[g])
    );
  end

  logic sfq_p, s_p, c_p;
  assign sfq_p = strobes[0];
  assign s_p   = strobes[1];
  assign c_p   = strobes[2];

  // ---------------- FSM
  state_e     state, state_nxt;
  logic [1:0] warm_cnt;
  logic       open_win, close_win, in_collect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WARMUP;
      warm_cnt <= '0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= (state == WARMUP) ? warm_cnt + 2'd1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WARMUP:  if (warm_cnt == 2'(WARMUP_CYC - 1)) state_nxt = IDLE;
      IDLE:    if (sfq_p) state_nxt = COLLECT;
      COLLECT: state_nxt = COLLECT;
      default: state_nxt = WARMUP;
    endcase
  end

  always_comb begin
    open_win   = (state == IDLE) && sfq_p;
    close_win  = (state == COLLECT) && sfq_p;
    in_collect = (state == COLLECT);
  end

  // ---------------- window flags and word assembly
  logic [IDX_W-1:0]  idx;
  logic              s_seen, c_seen, s_hit, c_hit;
  logic [WORD_W-1:0] s_word, c_word, s_full, c_full;
  logic              push_vld;
  logic [WORD_W-1:0] push_s, push_c;

  // A data strobe coincident with the SFQ strobe belongs to the closing window.
  assign s_hit = s_seen | s_p;
  assign c_hit = c_seen | c_p;

  always_comb begin
    s_full      = s_word;
    c_full      = c_word;
    s_full[idx] = s_hit;
    c_full[idx] = c_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      s_seen   <= 1'b0;
      c_seen   <= 1'b0;
      s_word   <= '0;
      c_word   <= '0;
      push_vld <= 1'b0;
      push_s   <= '0;
      push_c   <= '0;
    end else begin
      push_vld <= 1'b0;
      if (open_win) begin
        idx    <= '0;
        s_seen <= 1'b0;
        c_seen <= 1'b0;
      end else if (close_win) begin
        s_word[idx] <= s_hit;
        c_word[idx] <= c_hit;
        s_seen      <= 1'b0;
        c_seen      <= 1'b0;
        if (idx == IDX_W'(WORD_W - 1)) begin
          // Completed word is staged one cycle before entering the FIFO.
          idx      <= '0;
          push_vld <= 1'b1;
          push_s   <= s_full;
          push_c   <= c_full;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else if (in_collect) begin
        s_seen <= s_hit;
        c_seen <= c_hit;
      end
    end
  end

`ifdef HA_COLLECT_CHECK_EN
  // ---------------- protocol checks
  logic s_dup, c_dup, err_now;

  // Repeat strobe in a window, including one landing with the closing strobe.
  assign err_now = close_win &&
                   ((s_hit & c_hit) | s_dup | c_dup | (s_seen & s_p) | (c_seen & c_p));

  always_ff @(posedge clk) begin
    if (rst) begin
      s_dup   <= 1'b0;
      c_dup   <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (open_win || close_win) begin
        s_dup <= 1'b0;
        c_dup <= 1'b0;
      end else if (in_collect) begin
        s_dup <= s_dup | (s_seen & s_p);
        c_dup <= c_dup | (c_seen & c_p);
      end
      if (err_now && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
    end
  end
`endif

  // ---------------- word FIFO
  logic [WORD_W-1:0] mem_s [FIFO_DEPTH];
  logic [WORD_W-1:0] mem_c [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, pop, push_ok;

  assign full       = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign word_valid = (count != '0);
  assign pop        = word_valid && word_ready;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok    = push_vld && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_s[wr_ptr] <= push_s;
      mem_c[wr_ptr] <= push_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      if (push_vld && !push_ok) overflow <= 1'b1;
    end
  end

  assign word_s = word_valid ? mem_s[rd_ptr] : '0;
  assign word_c = word_valid ? mem_c[rd_ptr] : '0;
endmodule

// File: tb/tb_ha_result_collector.sv
// Randomized scoreboard bench for ha_result_collector (WORD_W=8, FIFO_DEPTH=4).
module tb_ha_result_collector;
  import ha_collect_pkg::*;

  logic       clk, rst, sfq_clk_in, s_in, cout_in, word_ready;
  logic [7:0] word_s, word_c;
  logic       word_valid, overflow;
`ifdef HA_COLLECT_CHECK_EN
  logic [7:0] err_cnt;
`endif

  ha_result_collector #(.WORD_W(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sfq_clk_in (sfq_clk_in),
    .s_in       (s_in),
    .cout_in    (cout_in),
    .word_s     (word_s),
    .word_c     (word_c),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow)
`ifdef HA_COLLECT_CHECK_EN
    ,.err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] s; logic [7:0] c; } word_t;
  word_t exp_q[$];

  int tests = 0, fails = 0;

  // Reference model: windows opened by the first SFQ toggle, one bit per window.
  bit   m_open;
  int   m_idx;
  bit [7:0] m_s, m_c;
  bit   stall;      // consumer held off: queue depth equals FIFO occupancy
  bit   exp_ovf;
  int   err_model;
  int   ready_mode; // 0 low, 1 high, 2 random

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void model_sfq(input bit s, input bit c, input bit err);
    word_t w;
    if (!m_open) begin
      m_open = 1;
      m_idx  = 0;
      return;
    end
    m_s[m_idx] = s;
    m_c[m_idx] = c;
    err_model  = (err && err_model < 255) ? err_model + 1 : err_model;
    if (m_idx == 7) begin
      w.s = m_s;
      w.c = m_c;
      if (stall && exp_q.size() >= 4) exp_ovf = 1;
      else exp_q.push_back(w);
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic open_win();
    sfq_clk_in = ~sfq_clk_in;
    model_sfq(0, 0, 0);
    cyc(2);
  endtask

  task automatic win(input bit s, input bit c);
    if (s) s_in = ~s_in;
    if (c) cout_in = ~cout_in;
    cyc(2);
    sfq_clk_in = ~sfq_clk_in;
    model_sfq(s, c, s && c);
    cyc(2);
  endtask

  // s toggle lands in the same clk cycle as the closing SFQ toggle
  task automatic win_same();
    s_in = ~s_in;
    sfq_clk_in = ~sfq_clk_in;
    model_sfq(1, 0, 0);
    cyc(2);
  endtask

  task automatic win_double_s();
    s_in = ~s_in; cyc(2);
    s_in = ~s_in; cyc(2);
    sfq_clk_in = ~sfq_clk_in;
    model_sfq(1, 0, 1);
    cyc(2);
  endtask

  task automatic win_rand();
    int t;
    t = int'($urandom_range(0, 3));
    case (t)
      0: win(0, 0);
      1: win(1, 0);
      2: win(0, 1);
      default: win_same();
    endcase
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) cyc(1);
    check(nm, exp_q.size(), 0);
  endtask

  // consumer ready driver
  initial begin
    word_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       word_ready = 1'b0;
        1:       word_ready = 1'b1;
        default: word_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: every accepted word is checked against the scoreboard
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got s=0x%0h c=0x%0h expected none", word_s, word_c);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        if (word_s !== e.s || word_c !== e.c) begin
          fails++;
          $display("FAIL word: got s=0x%0h c=0x%0h expected s=0x%0h c=0x%0h",
                   word_s, word_c, e.s, e.c);
        end
      end
    end
  end

  initial begin
    logic [7:0] ps, pc;
    rst = 1'b1; sfq_clk_in = 1'b1; s_in = 1'b1; cout_in = 1'b1;
    ready_mode = 1; m_open = 0; m_idx = 0; m_s = 0; m_c = 0;
    stall = 0; exp_ovf = 0; err_model = 0;

    // ---- reset with all lines high, then idle
    cyc(4);
    rst = 1'b0;
    cyc(20);
    check("rst_state_idle", 32'(dut.state), 32'(IDLE));
    check("rst_word_valid", word_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_word_s", word_s, 0);
    check("rst_word_c", word_c, 0);
`ifdef HA_COLLECT_CHECK_EN
    check("rst_err_cnt", err_cnt, 0);
`endif

    // ---- directed word 0xB2 / 0x4C with latency check on the last window
    ps = 8'hB2; pc = 8'h4C;
    open_win();
    for (int i = 0; i < 7; i++) win(ps[i], pc[i]);
    if (ps[7]) s_in = ~s_in;
    if (pc[7]) cout_in = ~cout_in;
    cyc(2);
    sfq_clk_in = ~sfq_clk_in;
    model_sfq(ps[7], pc[7], 0);
    cyc(4);
    check("latency_not_before_E4", word_valid, 0);
    cyc(1);
    check("latency_valid_at_E4", word_valid, 1);
    check("latency_word_s", word_s, 32'h0B2);
    check("latency_word_c", word_c, 32'h04C);
    drain("drain_basic");

    // ---- s toggle coincident with closing SFQ toggle lands in bit 3
    for (int i = 0; i < 3; i++) win(0, 0);
    win_same();
    for (int i = 0; i < 4; i++) win(0, 0);
    drain("drain_same_cycle");

    // ---- random windows with random backpressure
    ready_mode = 2;
    for (int w = 0; w < 6; w++)
      for (int i = 0; i < 8; i++) win_rand();
    drain("drain_random");

    // ---- overflow: 5 words against a stalled consumer
    ready_mode = 0;
    cyc(2);
    stall = 1;
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 8; i++) win_rand();
    cyc(8);
    check("ovf_flag", overflow, 32'(exp_ovf));
    check("ovf_queue_depth", exp_q.size(), 4);
    check("ovf_valid_held", word_valid, 1);
    stall = 0;
    ready_mode = 1;
    drain("drain_overflow");
    check("ovf_sticky", overflow, 1);
    check("ovf_empty_after_drain", word_valid, 0);

    // ---- reset after 3 bits of a word, then a clean word
    ready_mode = 2;
    win(1, 0); win(0, 1); win(1, 0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    m_open = 0; m_idx = 0; exp_ovf = 0; err_model = 0;
    cyc(6);
    check("midrst_overflow_cleared", overflow, 0);
    check("midrst_valid", word_valid, 0);
    check("midrst_state_idle", 32'(dut.state), 32'(IDLE));
    open_win();
    for (int i = 0; i < 8; i++) win_rand();
    drain("drain_midrst");

`ifdef HA_COLLECT_CHECK_EN
    // ---- protocol errors: s+cout window and double-s window
    ready_mode = 1;
    check("err_before", err_cnt, 32'(err_model));
    win(1, 1);
    win_double_s();
    for (int i = 0; i < 6; i++) win(0, 0);
    drain("drain_err");
    check("err_cnt", err_cnt, 32'(err_model));
    check("err_cnt_two", err_cnt, 2);
`endif

    cyc(4);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
